// File: rtl/sudoku_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : sudoku_pkg                                                 |
// | Purpose  : Shared grid geometry, completion status and controller     |
// |            state encodings for the sudoku job sequencer.              |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package sudoku_pkg;

  localparam int CELLS  = 81;
  localparam int CELL_W = 9;
  localparam int GRID_W = CELLS * CELL_W;

  typedef enum logic [1:0] {
    STAT_SOLVED  = 2'd0,
    STAT_STUCK   = 2'd1,
    STAT_ERROR   = 2'd2,
    STAT_TIMEOUT = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CLR   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/sudoku_cell_codec.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sudoku_cell_codec                                          |
// | Purpose  : Combinational translation between a 4-bit cell digit and   |
// |            the 9-bit candidate vector used by the solver.             |
// | Ports    : digit     - input digit (0 empty, 1-9 given, 10-15 illegal)|
// |            cand      - candidate vector (one-hot or 9'h1FF)           |
// |            illegal   - digit is 10..15                                |
// |            onehot    - candidate vector to decode                     |
// |            dec_digit - decoded digit, 0 unless exactly one bit set    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module sudoku_cell_codec
  import sudoku_pkg::*;
(
  input  logic [3:0]        digit,
  output logic [CELL_W-1:0] cand,
  output logic              illegal,
  input  logic [CELL_W-1:0] onehot,
  output logic [3:0]        dec_digit
);

  always_comb begin
    illegal   = (digit > 4'd9);
    cand      = 9'h1FF;
    dec_digit = 4'd0;
    if ((digit != 4'd0) && !illegal) begin
      cand = CELL_W'(1) << (digit - 4'd1);
    end
    // A cell with zero or several candidates left is reported as unresolved.
    if ($onehot(onehot)) begin
      for (int d = 0; d < CELL_W; d++) begin
        if (onehot[d]) begin
          dec_digit = 4'(d + 1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sudoku_job_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sudoku_job_ctrl                                            |
// | Purpose  : Job sequencer for the sudoku solver. Loads 81 digits into  |
// |            a candidate grid, clears/starts the solver, supervises it  |
// |            with a watchdog and streams the solved grid back out with  |
// |            a completion status.                                       |
// | Ports    : in_valid/in_ready/in_digit     - puzzle digit stream       |
// |            out_valid/out_ready/out_digit/out_last - result stream     |
// |            status/status_valid            - completion status         |
// |            busy                           - job in progress           |
// |            slv_clr/slv_start              - solver control pulses     |
// |            slv_in_grid/slv_out_grid       - solver grids              |
// |            slv_unsolved/slv_all_done/slv_any_error/slv_timeout        |
// |                                           - solver flags              |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module sudoku_job_ctrl
  import sudoku_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_digit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_digit,
  output logic              out_last,
  output logic [1:0]        status,
  output logic              status_valid,
  output logic              busy,
  output logic              slv_clr,
  output logic              slv_start,
  output logic [GRID_W-1:0] slv_in_grid,
  input  logic [GRID_W-1:0] slv_out_grid,
  input  logic [6:0]        slv_unsolved,
  input  logic              slv_all_done,
  input  logic              slv_any_error,
  input  logic              slv_timeout
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [6:0]      LAST_IDX = 7'(CELLS - 1);

  ctrl_state_t       state, state_d;
  logic [6:0]        idx;
  logic [9:0]        cell_base;
  logic [GRID_W-1:0] result;
  logic              bad_in;
  status_t           status_q;
  logic [WD_W-1:0]   wdog;

  logic              run_exit;
  status_t           exit_status;

  logic [CELL_W-1:0] in_cand;
  logic              in_illegal;
  logic [3:0]        dec_digit;

  // Codec outputs not needed on each side of the datapath.
  logic [3:0]        unused_in_dec;
  logic [CELL_W-1:0] unused_out_cand;
  logic              unused_out_illegal;
  logic              unused_codec;

  // The same cell pointer addresses the load grid and the result grid.
  assign cell_base = 10'(idx) * 10'(CELL_W);

  sudoku_cell_codec u_in_codec (
    .digit     (in_digit),
    .cand      (in_cand),
    .illegal   (in_illegal),
    .onehot    ({CELL_W{1'b0}}),
    .dec_digit (unused_in_dec)
  );

  sudoku_cell_codec u_out_codec (
    .digit     (4'd0),
    .cand      (unused_out_cand),
    .illegal   (unused_out_illegal),
    .onehot    (result[cell_base +: CELL_W]),
    .dec_digit (dec_digit)
  );

  assign unused_codec = &{1'b0, unused_in_dec, unused_out_cand, unused_out_illegal};

  assign status    = status_q;
  assign out_digit = out_valid ? dec_digit : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d      = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    status_valid = 1'b0;
    busy         = 1'b1;
    slv_clr      = 1'b0;
    slv_start    = 1'b0;
    run_exit     = 1'b0;
    exit_status  = STAT_TIMEOUT;

    // Solver flags outrank the watchdog so a result arriving on the expiry
    // cycle is still reported.
    if (slv_any_error) begin
      run_exit    = 1'b1;
      exit_status = STAT_ERROR;
    end else if (slv_all_done) begin
      run_exit    = 1'b1;
      exit_status = (slv_unsolved == 7'd0) ? STAT_SOLVED : STAT_STUCK;
    end else if (slv_timeout || (wdog == WD_LAST)) begin
      run_exit    = 1'b1;
      exit_status = STAT_TIMEOUT;
    end

    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && (idx == LAST_IDX)) begin
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        slv_clr = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        slv_start = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (run_exit) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid    = 1'b1;
        status_valid = 1'b1;
        out_last     = (idx == LAST_IDX);
        if (out_ready && out_last) begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 7'd0;
      slv_in_grid <= '0;
      result      <= '0;
      bad_in      <= 1'b0;
      status_q    <= STAT_SOLVED;
      wdog        <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            slv_in_grid[cell_base +: CELL_W] <= in_cand;
            if (in_illegal) begin
              bad_in <= 1'b1;
            end
            idx <= (idx == LAST_IDX) ? 7'd0 : idx + 7'd1;
          end
        end
        S_START: begin
          wdog <= '0;
        end
        S_RUN: begin
          if (wdog != WD_MAX) begin
            wdog <= wdog + WD_W'(1);
          end
          if (run_exit) begin
            result   <= slv_out_grid;
            status_q <= bad_in ? STAT_ERROR : exit_status;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              idx    <= 7'd0;
              bad_in <= 1'b0;
            end else begin
              idx <= idx + 7'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sudoku_job_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_sudoku_job_ctrl                                         |
// | Purpose  : Self-checking bench for sudoku_job_ctrl. Two controllers   |
// |            (long and 16-cycle watchdog) share the stimulus; sel picks |
// |            which one is driven and observed.                          |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sudoku_job_ctrl;
  import sudoku_pkg::*;

  localparam int TMO_A = 4096;
  localparam int TMO_B = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              sel;
  logic              in_valid;
  logic [3:0]        in_digit;
  logic              out_ready;
  logic [GRID_W-1:0] slv_out_grid;
  logic [6:0]        slv_unsolved;
  logic              slv_all_done, slv_any_error, slv_timeout;

  logic a_in_valid, a_out_ready, b_in_valid, b_out_ready;
  logic a_in_ready, a_out_valid, a_out_last, a_status_valid, a_busy, a_slv_clr, a_slv_start;
  logic b_in_ready, b_out_valid, b_out_last, b_status_valid, b_busy, b_slv_clr, b_slv_start;
  logic [3:0] a_out_digit, b_out_digit;
  logic [1:0] a_status, b_status;
  logic [GRID_W-1:0] a_slv_in_grid, b_slv_in_grid;

  logic m_in_ready, m_out_valid, m_out_last, m_status_valid, m_busy, m_slv_clr, m_slv_start;
  logic [3:0] m_out_digit;
  logic [1:0] m_status;
  logic [GRID_W-1:0] m_slv_in_grid;

  assign a_in_valid  = in_valid && !sel;
  assign b_in_valid  = in_valid && sel;
  assign a_out_ready = out_ready && !sel;
  assign b_out_ready = out_ready && sel;

  assign m_in_ready     = sel ? b_in_ready     : a_in_ready;
  assign m_out_valid    = sel ? b_out_valid    : a_out_valid;
  assign m_out_last     = sel ? b_out_last     : a_out_last;
  assign m_status_valid = sel ? b_status_valid : a_status_valid;
  assign m_busy         = sel ? b_busy         : a_busy;
  assign m_slv_clr      = sel ? b_slv_clr      : a_slv_clr;
  assign m_slv_start    = sel ? b_slv_start    : a_slv_start;
  assign m_out_digit    = sel ? b_out_digit    : a_out_digit;
  assign m_status       = sel ? b_status       : a_status;
  assign m_slv_in_grid  = sel ? b_slv_in_grid  : a_slv_in_grid;

  sudoku_job_ctrl #(.TIMEOUT_CYCLES(TMO_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_digit(in_digit),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_digit(a_out_digit), .out_last(a_out_last),
    .status(a_status), .status_valid(a_status_valid), .busy(a_busy),
    .slv_clr(a_slv_clr), .slv_start(a_slv_start), .slv_in_grid(a_slv_in_grid),
    .slv_out_grid(slv_out_grid), .slv_unsolved(slv_unsolved),
    .slv_all_done(slv_all_done), .slv_any_error(slv_any_error), .slv_timeout(slv_timeout)
  );

  sudoku_job_ctrl #(.TIMEOUT_CYCLES(TMO_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_digit(in_digit),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_digit(b_out_digit), .out_last(b_out_last),
    .status(b_status), .status_valid(b_status_valid), .busy(b_busy),
    .slv_clr(b_slv_clr), .slv_start(b_slv_start), .slv_in_grid(b_slv_in_grid),
    .slv_out_grid(slv_out_grid), .slv_unsolved(slv_unsolved),
    .slv_all_done(slv_all_done), .slv_any_error(slv_any_error), .slv_timeout(slv_timeout)
  );

  int checks   = 0;
  int failures = 0;
  int job_no   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [GRID_W-1:0] got, input logic [GRID_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Valid solved grid; rot relabels the digits so each job differs.
  function automatic logic [3:0] digit_at(input int i, input int rot);
    int r, c;
    r = i / 9;
    c = i % 9;
    return 4'(((r * 3 + r / 3 + c + rot) % 9) + 1);
  endfunction

  function automatic logic [8:0] cand_of(input logic [3:0] dg);
    if (dg >= 4'd1 && dg <= 4'd9) return 9'b1 << (dg - 4'd1);
    return 9'h1FF;
  endfunction

  task automatic check_reset(input string name);
    check({name, "_rst_in_ready"}, m_in_ready, 1'b1);
    check({name, "_rst_out_valid"}, m_out_valid, 1'b0);
    check({name, "_rst_out_last"}, m_out_last, 1'b0);
    check({name, "_rst_status_valid"}, m_status_valid, 1'b0);
    check({name, "_rst_busy"}, m_busy, 1'b0);
    check({name, "_rst_clr"}, m_slv_clr, 1'b0);
    check({name, "_rst_start"}, m_slv_start, 1'b0);
    check({name, "_rst_status"}, m_status, 2'd0);
    check({name, "_rst_out_digit"}, m_out_digit, 4'd0);
    check({name, "_rst_in_grid"}, m_slv_in_grid, '0);
  endtask

  task automatic apply_reset(input string name);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    slv_all_done = 1'b0;
    slv_any_error = 1'b0;
    slv_timeout = 1'b0;
    #1;
    check_reset(name);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // delay < 0: solver stays silent. abort_run / abort_cell < 0: no abort.
  task automatic run_job(input logic use_b, input int bad_cell, input logic f_err, input logic f_done,
                         input logic f_tmo, input int n_unsolved, input int delay, input logic rand_ready,
                         input int abort_run, input int abort_cell, input string name);
    logic [GRID_W-1:0] exp_in, res;
    logic [3:0]        d, hold_digit;
    logic              hold_last, stalled;
    logic [1:0]        exp_st;
    int                run_cyc, sent;

    sel = use_b;
    job_no++;
    exp_q.delete();

    for (int i = 0; i < CELLS; i++) begin
      d = (((i * 37) % 81) < 30) ? digit_at(i, job_no) : 4'd0;
      if (i == bad_cell) d = 4'd12;
      exp_in[i * CELL_W +: CELL_W] = cand_of(d);
      @(negedge clk);
      if (i == 0) check({name, "_in_ready"}, m_in_ready, 1'b1);
      in_valid = 1'b1;
      in_digit = d;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_digit = 4'd0;
    check({name, "_clr_n1"}, m_slv_clr, 1'b1);
    check({name, "_start_n1"}, m_slv_start, 1'b0);
    check({name, "_in_ready_busy"}, m_in_ready, 1'b0);
    check({name, "_busy"}, m_busy, 1'b1);
    check({name, "_in_grid"}, m_slv_in_grid, exp_in);
    if (bad_cell >= 0) check({name, "_bad_cell_1ff"}, m_slv_in_grid[bad_cell * CELL_W +: CELL_W], 9'h1FF);
    @(negedge clk);
    check({name, "_start_n2"}, m_slv_start, 1'b1);
    check({name, "_clr_n2"}, m_slv_clr, 1'b0);

    // Solver result grid; the first n_unsolved cells are left ambiguous.
    for (int i = 0; i < CELLS; i++) begin
      if (i < n_unsolved) begin
        res[i * CELL_W +: CELL_W] = (i == 0) ? 9'h000 : (9'h003 << (i % 7));
        exp_q.push_back(4'd0);
      end else begin
        res[i * CELL_W +: CELL_W] = cand_of(digit_at(i, job_no));
        exp_q.push_back(digit_at(i, job_no));
      end
    end
    slv_out_grid = res;
    slv_unsolved = 7'(n_unsolved);
    if (bad_cell >= 0)     exp_st = 2'd2;
    else if (delay < 0)    exp_st = 2'd3;
    else if (f_err)        exp_st = 2'd2;
    else if (f_done)       exp_st = (n_unsolved == 0) ? 2'd0 : 2'd1;
    else                   exp_st = 2'd3;

    run_cyc = 0;
    forever begin
      @(negedge clk);
      if (m_out_valid) break;
      run_cyc++;
      if (run_cyc == abort_run) return;
      if (run_cyc > 5000) begin
        check({name, "_run_budget"}, 1'b0, 1'b1);
        slv_all_done = 1'b0; slv_any_error = 1'b0; slv_timeout = 1'b0;
        return;
      end
      if (run_cyc == delay) begin
        slv_any_error = f_err;
        slv_all_done  = f_done;
        slv_timeout   = f_tmo;
      end
    end
    slv_all_done = 1'b0;
    slv_any_error = 1'b0;
    slv_timeout = 1'b0;
    check({name, "_run_cycles"}, 32'(run_cyc), (delay > 0) ? 32'(delay) : 32'(use_b ? TMO_B : TMO_A));
    check({name, "_status_valid"}, m_status_valid, 1'b1);
    check({name, "_status"}, m_status, exp_st);

    sent = 0;
    stalled = 1'b0;
    hold_digit = 4'd0;
    hold_last = 1'b0;
    for (int cyc = 0; cyc < 2000 && sent < CELLS; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!m_out_valid) begin
        check({name, "_valid_held"}, m_out_valid, 1'b1);
        break;
      end
      if (stalled) begin
        check({name, "_stall_digit"}, m_out_digit, hold_digit);
        check({name, "_stall_last"}, m_out_last, hold_last);
      end
      if (sent == abort_cell) begin
        out_ready = 1'b0;
        return;
      end
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_ready) begin
        check($sformatf("%s_digit%0d", name, sent), m_out_digit, exp_q.pop_front());
        check($sformatf("%s_last%0d", name, sent), m_out_last, (sent == CELLS - 1));
        sent++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hold_digit = m_out_digit;
        hold_last = m_out_last;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_sent"}, 32'(sent), 32'(CELLS));
    check({name, "_end_valid"}, m_out_valid, 1'b0);
    check({name, "_end_status_valid"}, m_status_valid, 1'b0);
    check({name, "_end_busy"}, m_busy, 1'b0);
    check({name, "_end_in_ready"}, m_in_ready, 1'b1);
  endtask

  initial begin
    sel = 1'b0;
    in_valid = 1'b0;
    in_digit = 4'd0;
    out_ready = 1'b0;
    slv_out_grid = '0;
    slv_unsolved = 7'd0;
    slv_all_done = 1'b0;
    slv_any_error = 1'b0;
    slv_timeout = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    run_job(1'b0, -1, 1'b0, 1'b1, 1'b0, 0,  500, 1'b0, -1, -1, "solve");
    run_job(1'b0, -1, 1'b0, 1'b1, 1'b0, 12, 20,  1'b1, -1, -1, "stuck");
    run_job(1'b0, -1, 1'b1, 1'b1, 1'b0, 0,  5,   1'b0, -1, -1, "err");
    run_job(1'b0, 5,  1'b0, 1'b1, 1'b0, 0,  8,   1'b0, -1, -1, "badin");
    run_job(1'b0, -1, 1'b0, 1'b0, 1'b1, 0,  7,   1'b0, -1, -1, "slvtmo");
    run_job(1'b1, -1, 1'b0, 1'b0, 1'b0, 0,  -1,  1'b0, -1, -1, "wdog");
    run_job(1'b1, -1, 1'b0, 1'b1, 1'b0, 0,  16,  1'b0, -1, -1, "wdraw");
    run_job(1'b0, -1, 1'b0, 1'b1, 1'b0, 0,  300, 1'b0, 10, -1, "rstrun");
    apply_reset("rstrun");
    run_job(1'b0, -1, 1'b0, 1'b1, 1'b0, 0,  30,  1'b1, -1, 40, "rstdrn");
    apply_reset("rstdrn");
    run_job(1'b0, -1, 1'b0, 1'b1, 1'b0, 0,  40,  1'b1, -1, -1, "clean");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
